// File: rtl/tm_pkg.sv
// tm_pkg: shared widths, head start position and run-status encoding for the TM run controller.
package tm_pkg;
  localparam int TM_ADDR_W = 6;
  localparam int TM_SYM_W = 3;
  localparam int TM_CNT_W = 40;
  localparam logic [TM_ADDR_W-1:0] TM_HEAD_INIT = TM_ADDR_W'(1 << (TM_ADDR_W - 1));
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_HALTED = 3'd3,
    ST_LIMIT  = 3'd4,
    ST_ERROR  = 3'd5,
    ST_DUMP   = 3'd6
  } tm_status_e;
endpackage

// File: rtl/tm_dump_stream.sv
// tm_dump_stream: walks the tape pointer and streams one symbol per beat over valid/ready.
module tm_dump_stream
  import tm_pkg::*;
#(
  parameter int ADDR_W = TM_ADDR_W,
  parameter int SYM_W  = TM_SYM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ready,
  input  logic [SYM_W-1:0]  rdata,
  output logic [ADDR_W-1:0] ptr,
  output logic              valid,
  output logic [SYM_W-1:0]  data,
  output logic              last,
  output logic              fin
);
  logic load;
  // once the last beat is loaded no further reads happen; it only waits for acceptance
  assign load = en && (!valid || (ready && !last));
  assign fin = en && valid && last && ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      valid <= 1'b0;
      data <= '0;
      last <= 1'b0;
    end else if (!en) begin
      ptr <= '0;
      valid <= 1'b0;
      last <= 1'b0;
    end else if (load) begin
      data <= rdata;
      last <= &ptr;
      valid <= 1'b1;
      ptr <= ptr + ADDR_W'(1);
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/tm_run_ctrl.sv
// tm_run_ctrl: sequences clear, run, finish and tape dump for the Turing-machine core.
module tm_run_ctrl
  import tm_pkg::*;
#(
  parameter int          ADDR_W     = TM_ADDR_W,
  parameter int          SYM_W      = TM_SYM_W,
  parameter int          CNT_W      = TM_CNT_W,
  parameter int unsigned STEP_LIMIT = 0
) (
  input  logic              CLK_66MHZ,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              abort,
  input  logic              single_step,
  input  logic              step_req,
  output logic              core_rst,
  output logic              core_step_en,
  input  logic              core_halt,
  input  logic              core_err,
  output logic              tape_sel,
  output logic [ADDR_W-1:0] tape_addr,
  output logic              tape_we,
  output logic [SYM_W-1:0]  tape_wdata,
  input  logic [SYM_W-1:0]  tape_rdata,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  step_count,
  output logic              done,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [SYM_W-1:0]  dump_data,
  output logic              dump_last
);
  tm_status_e state, next_state;
  logic [ADDR_W-1:0] clr_addr, ptr;
  logic finished, go, lim_hit, fin, dump_en;
  assign finished = state inside {ST_HALTED, ST_LIMIT, ST_ERROR};
  assign go = start && !abort && (state == ST_IDLE || finished);
  // abort also blocks the step in its own cycle so the count reads back unchanged
  assign core_step_en = state == ST_RUN && !abort && !core_halt && !core_err && (!single_step || step_req);
  assign lim_hit = STEP_LIMIT != 0 && core_step_en && step_count + CNT_W'(1) == CNT_W'(STEP_LIMIT);
  assign core_rst = state == ST_IDLE || state == ST_CLEAR;
  assign tape_sel = state != ST_RUN;
  assign tape_we = state == ST_CLEAR;
  assign tape_wdata = '0;
  assign tape_addr = state == ST_CLEAR ? clr_addr : ptr;
  assign status = state;
  assign dump_en = state == ST_DUMP && !abort;
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:                       next_state = start ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:                      next_state = &clr_addr ? ST_RUN : ST_CLEAR;
      ST_RUN:                        next_state = core_err ? ST_ERROR : core_halt ? ST_HALTED : lim_hit ? ST_LIMIT : ST_RUN;
      ST_HALTED, ST_LIMIT, ST_ERROR: next_state = start ? ST_CLEAR : ST_DUMP;
      ST_DUMP:                       next_state = fin ? ST_IDLE : ST_DUMP;
      default:                       next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;
  end
  always_ff @(posedge CLK_66MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      clr_addr <= '0;
      step_count <= '0;
      done <= 1'b0;
    end else begin
      state <= next_state;
      clr_addr <= state == ST_CLEAR ? clr_addr + ADDR_W'(1) : '0;
      step_count <= go ? '0 : core_step_en ? step_count + CNT_W'(1) : step_count;
      done <= (abort || go) ? 1'b0 : (next_state inside {ST_HALTED, ST_LIMIT, ST_ERROR}) ? 1'b1 : done;
    end
  end
  tm_dump_stream #(.ADDR_W(ADDR_W), .SYM_W(SYM_W)) u_dump (
    .clk(CLK_66MHZ),
    .rst_n(RESET_N),
    .en(dump_en),
    .ready(dump_ready),
    .rdata(tape_rdata),
    .ptr(ptr),
    .valid(dump_valid),
    .data(dump_data),
    .last(dump_last),
    .fin(fin)
  );
endmodule

// File: tb/tb_tm_run_ctrl.sv
// tb_tm_run_ctrl: scoreboard bench driving tm_run_ctrl with a counting core stub and a tape model.
module tb_tm_run_ctrl;
  import tm_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, abort = 0, single_step = 0, step_req = 0, dump_ready = 0, start_l = 0;
  logic core_rst, core_step_en, core_halt, core_err, tape_sel, tape_we, done;
  logic dump_valid, dump_last;
  logic [5:0] tape_addr;
  logic [2:0] tape_wdata, tape_rdata, dump_data, status;
  logic [39:0] step_count;
  logic core_rst_l, core_step_en_l, tape_sel_l, tape_we_l, done_l, dump_valid_l, dump_last_l;
  logic [5:0] tape_addr_l;
  logic [2:0] tape_wdata_l, dump_data_l, status_l;
  logic [39:0] step_count_l;
  int vectors = 0, miscompares = 0;
  int halt_at = 0, err_at = 0, stub_steps = 0, en_cycles = 0;
  logic preload = 0;
  logic [2:0] tape [64];
  logic [5:0] q_addr [$];
  logic [2:0] q_sym [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_rst) stub_steps <= 0;
    else if (core_step_en) stub_steps <= stub_steps + 1;
    if (core_step_en) en_cycles <= en_cycles + 1;
    if (tape_sel && tape_we) tape[tape_addr] <= tape_wdata;
    else if (preload) for (int k = 0; k < 64; k++) tape[k] <= 3'(k % 5);
  end
  assign core_halt = halt_at != 0 && stub_steps == halt_at;
  assign core_err = err_at != 0 && stub_steps == err_at;
  assign tape_rdata = tape[tape_addr];

  tm_run_ctrl dut (
    .CLK_66MHZ(clk), .RESET_N(rst_n), .start(start), .abort(abort),
    .single_step(single_step), .step_req(step_req), .core_rst(core_rst),
    .core_step_en(core_step_en), .core_halt(core_halt), .core_err(core_err),
    .tape_sel(tape_sel), .tape_addr(tape_addr), .tape_we(tape_we),
    .tape_wdata(tape_wdata), .tape_rdata(tape_rdata), .status(status),
    .step_count(step_count), .done(done), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last)
  );

  tm_run_ctrl #(.STEP_LIMIT(16)) u_lim (
    .CLK_66MHZ(clk), .RESET_N(rst_n), .start(start_l), .abort(1'b0),
    .single_step(1'b0), .step_req(1'b0), .core_rst(core_rst_l),
    .core_step_en(core_step_en_l), .core_halt(1'b0), .core_err(1'b0),
    .tape_sel(tape_sel_l), .tape_addr(tape_addr_l), .tape_we(tape_we_l),
    .tape_wdata(tape_wdata_l), .tape_rdata(3'd0), .status(status_l),
    .step_count(step_count_l), .done(done_l), .dump_ready(dump_ready),
    .dump_valid(dump_valid_l), .dump_data(dump_data_l), .dump_last(dump_last_l)
  );

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if (status !== 3'd0 || core_rst !== 1'b1 || core_step_en !== 1'b0 || tape_sel !== 1'b1 ||
        tape_we !== 1'b0 || tape_addr !== 6'd0 || step_count !== 40'd0 || done !== 1'b0 ||
        dump_valid !== 1'b0 || dump_last !== 1'b0 || dump_data !== 3'd0) begin
      miscompares++;
      $display("FAIL reset: status=%0d rst=%b en=%b sel=%b we=%b addr=%0d cnt=%0d done=%b dv=%b dl=%b dd=%0d want 0 1 0 1 0 0 0 0 0 0 0",
               status, core_rst, core_step_en, tape_sel, tape_we, tape_addr, step_count, done, dump_valid, dump_last, dump_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_halt;
    int n = 0, base;
    halt_at = 1000;
    err_at = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 64; k++) q_addr.push_back(6'(k));
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (status !== 3'd1 || step_count !== 40'd0) begin
      miscompares++;
      $display("FAIL clear_entry: status=%0d cnt=%0d want 1 0", status, step_count);
    end
    for (int k = 0; k < 64; k++) begin
      logic [5:0] e;
      e = q_addr.pop_front();
      vectors++;
      if (tape_we !== 1'b1 || tape_addr !== e || tape_wdata !== 3'd0 || core_rst !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_write%0d: we=%b addr=%0d data=%0d rst=%b want 1 %0d 0 1", k, tape_we, tape_addr, tape_wdata, core_rst, e);
      end
      @(negedge clk);
    end
    vectors++;
    if (status !== 3'd2 || tape_sel !== 1'b0 || core_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL run_entry: status=%0d sel=%b rst=%b want 2 0 0", status, tape_sel, core_rst);
    end
    base = en_cycles;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    while (status === 3'd2 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (status !== 3'd3 || step_count !== 40'd1000 || done !== 1'b1 || en_cycles - base != 1000) begin
      miscompares++;
      $display("FAIL halt: status=%0d cnt=%0d done=%b en_cycles=%0d want 3 1000 1 1000", status, step_count, done, en_cycles - base);
    end
  endtask

  task automatic test_dump;
    int beats = 0, cyc = 0;
    logic held = 0, hl = 0;
    logic [2:0] hd = 0, e;
    for (int k = 0; k < 64; k++) q_sym.push_back(3'(k % 5));
    while (beats < 64 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        vectors++;
        if (dump_valid !== 1'b1 || dump_data !== hd || dump_last !== hl) begin
          miscompares++;
          $display("FAIL dump_stall%0d: v=%b d=%0d l=%b want 1 %0d %b", beats, dump_valid, dump_data, dump_last, hd, hl);
        end
      end
      dump_ready = (cyc % 2) == 0;
      if (dump_valid && dump_ready) begin
        e = q_sym.pop_front();
        vectors++;
        if (dump_data !== e || dump_last !== (beats == 63)) begin
          miscompares++;
          $display("FAIL dump_beat%0d: d=%0d l=%b want %0d %b", beats, dump_data, dump_last, e, beats == 63);
        end
        beats++;
      end
      held = dump_valid && !dump_ready;
      hd = dump_data;
      hl = dump_last;
    end
    if (beats < 64) begin
      miscompares++;
      $display("FAIL dump_timeout: beats=%0d want 64", beats);
    end
    @(negedge clk);
    dump_ready = 1'b1;
    vectors++;
    if (status !== 3'd0 || done !== 1'b1 || dump_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_end: status=%0d done=%b v=%b want 0 1 0", status, done, dump_valid);
    end
  endtask

  task automatic test_limit_err;
    int n = 0;
    @(negedge clk);
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    while (!(status_l inside {3'd3, 3'd4, 3'd5}) && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (status_l !== 3'd4 || step_count_l !== 40'd16 || done_l !== 1'b1) begin
      miscompares++;
      $display("FAIL limit: status=%0d cnt=%0d done=%b want 4 16 1", status_l, step_count_l, done_l);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    halt_at = 0;
    err_at = 7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(status inside {3'd3, 3'd4, 3'd5}) && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (status !== 3'd5 || step_count !== 40'd7 || done !== 1'b1 || core_step_en !== 1'b0) begin
      miscompares++;
      $display("FAIL error: status=%0d cnt=%0d done=%b en=%b want 5 7 1 0", status, step_count, done, core_step_en);
    end
  endtask

  task automatic test_abort;
    int n = 0;
    err_at = 0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (step_count !== 40'd300 && n < 600) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    start = 1'b1;
    #1;
    vectors++;
    if (core_step_en !== 1'b0 || status !== 3'd2) begin
      miscompares++;
      $display("FAIL abort_same_cycle: en=%b status=%0d want 0 2", core_step_en, status);
    end
    @(negedge clk);
    vectors++;
    if (status !== 3'd0 || core_step_en !== 1'b0 || step_count !== 40'd300 || done !== 1'b0 || dump_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: status=%0d en=%b cnt=%0d done=%b v=%b want 0 0 300 0 0", status, core_step_en, step_count, done, dump_valid);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_single_step;
    int n = 0, base;
    single_step = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (status !== 3'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    base = en_cycles;
    for (int c = 0; c < 50; c++) begin
      step_req = (c == 10 || c == 25 || c == 40);
      if (c == 10 || c == 11) begin
        #1;
        vectors++;
        if (core_step_en !== (c == 10)) begin
          miscompares++;
          $display("FAIL single_en%0d: en=%b want %b", c, core_step_en, c == 10);
        end
      end
      @(negedge clk);
    end
    step_req = 1'b0;
    vectors++;
    if (step_count !== 40'd3 || en_cycles - base != 3 || status !== 3'd2) begin
      miscompares++;
      $display("FAIL single_step: cnt=%0d en_cycles=%0d status=%0d want 3 3 2", step_count, en_cycles - base, status);
    end
    single_step = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int n = 0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (step_count !== 40'd500 && n < 700) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (step_count !== 40'd500) begin
      miscompares++;
      $display("FAIL reach_500: cnt=%0d want 500", step_count);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (status !== 3'd0 || step_count !== 40'd0 || core_rst !== 1'b1 || core_step_en !== 1'b0 ||
        tape_sel !== 1'b1 || tape_we !== 1'b0 || tape_addr !== 6'd0 || done !== 1'b0 || dump_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: status=%0d cnt=%0d rst=%b en=%b sel=%b we=%b addr=%0d done=%b v=%b want 0 0 1 0 1 0 0 0 0",
               status, step_count, core_rst, core_step_en, tape_sel, tape_we, tape_addr, done, dump_valid);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (status !== 3'd0 || step_count !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_hold: status=%0d cnt=%0d want 0 0", status, step_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_halt();
    test_dump();
    test_limit_err();
    test_abort();
    test_single_step();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
